// File: rtl/mips_control.sv
// mips_control: multicycle control unit for the MIPS datapath.
//
// Sequences every instruction through FETCH/DECO/EXE/MEM/WB and drives all
// datapath enables, mux selects and memory strobes. Outputs are a
// combinational function of state, opcode, funct and zero. They are forced
// to 0 while reset is high.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   opcode, funct      instruction register fields IR[31:26], IR[5:0]
//   zero               ALU zero flag, used only by beq/bne in EXE
//   pc_ld, ir_w        PC load, instruction register write
//   reg_rd, reg_wr     register bank read / write enables
//   mem_rd, mem_wd     memory read / write strobes
//   sel_dir            memory address source (0 PC, 1 RegALU)
//   sel_dest           write register (0 rt, 1 rd)
//   sel_dat            write data (0 RegALU, 1 RegMemoria)
//   sel_operB          ALU operand B (0 PC, 1 RegA)
//   sel_pc             next PC (0 ALU, 1 RegALU, 2 jump concat)
//   sel_operA          ALU operand A (0 RegB, 1 sext imm, 2 imm<<2, 3 const 4)
//   alu_fun            ALU op (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT)
//   state              current state encoding
//   illegal            one-cycle pulse in DECO for unsupported instructions
//   retired            count of completed legal instructions (wraps)
//
// state | meaning
// ------+-----------------------------------------------------------
// FETCH | read instruction into IR, PC <= PC + 4
// DECO  | read register bank, RegALU <= branch target; j or illegal ends here
// EXE   | ALU operation; beq/bne resolve and end here
// MEM   | lw read / sw write at the address held in RegALU
// WB    | register bank write for R-type, addi and lw
module mips_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_ld,
    output logic        ir_w,
    output logic        reg_rd,
    output logic        reg_wr,
    output logic        mem_rd,
    output logic        mem_wd,
    output logic        sel_dir,
    output logic        sel_dest,
    output logic        sel_dat,
    output logic        sel_operB,
    output logic [1:0]  sel_pc,
    output logic [2:0]  sel_operA,
    output logic [2:0]  alu_fun,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        DECO  = 3'd1,
        EXE   = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    state_t      state_q;
    state_t      state_d;
    logic        retire;

    logic        r_fun_ok;
    logic [2:0]  r_fun;
    logic        is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j;
    logic        is_branch, is_mem, is_legal;
    logic [2:0]  exe_a;
    logic [2:0]  exe_f;

    always_comb begin
        r_fun_ok = 1'b1;
        r_fun    = ALU_ADD;
        case (funct)
            6'h20:   r_fun = ALU_ADD;
            6'h22:   r_fun = ALU_SUB;
            6'h24:   r_fun = ALU_AND;
            6'h25:   r_fun = ALU_OR;
            6'h2A:   r_fun = ALU_SLT;
            default: r_fun_ok = 1'b0;
        endcase
    end

    assign is_r      = (opcode == OP_R) && r_fun_ok;
    assign is_lw     = (opcode == OP_LW);
    assign is_sw     = (opcode == OP_SW);
    assign is_beq    = (opcode == OP_BEQ);
    assign is_bne    = (opcode == OP_BNE);
    assign is_addi   = (opcode == OP_ADDI);
    assign is_j      = (opcode == OP_J);
    assign is_branch = is_beq | is_bne;
    assign is_mem    = is_lw | is_sw;
    assign is_legal  = is_r | is_mem | is_branch | is_addi | is_j;

    // ALU selects chosen in EXE; MEM and WB repeat them so RegALU holds.
    always_comb begin
        exe_a = 3'd0;
        exe_f = ALU_ADD;
        if (is_r) begin
            exe_a = 3'd0;
            exe_f = r_fun;
        end else if (is_mem || is_addi) begin
            exe_a = 3'd1;
            exe_f = ALU_ADD;
        end else if (is_branch) begin
            exe_a = 3'd0;
            exe_f = ALU_SUB;
        end
    end

    always_comb begin
        pc_ld     = 1'b0;
        ir_w      = 1'b0;
        reg_rd    = 1'b0;
        reg_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_wd    = 1'b0;
        sel_dir   = 1'b0;
        sel_dest  = 1'b0;
        sel_dat   = 1'b0;
        sel_operB = 1'b0;
        sel_pc    = 2'd0;
        sel_operA = 3'd0;
        alu_fun   = ALU_ADD;
        illegal   = 1'b0;
        retire    = 1'b0;
        state_d   = FETCH;

        case (state_q)
            FETCH: begin
                mem_rd    = 1'b1;
                ir_w      = 1'b1;
                sel_operA = 3'd3;
                pc_ld     = 1'b1;
                state_d   = DECO;
            end
            DECO: begin
                reg_rd    = 1'b1;
                sel_operA = 3'd2;
                if (!is_legal) begin
                    illegal = 1'b1;
                end else if (is_j) begin
                    sel_pc = 2'd2;
                    pc_ld  = 1'b1;
                    retire = 1'b1;
                end else begin
                    state_d = EXE;
                end
            end
            EXE: begin
                if (is_legal && !is_j) begin
                    sel_operB = 1'b1;
                    sel_operA = exe_a;
                    alu_fun   = exe_f;
                end
                if (is_branch) begin
                    // RegALU still holds the target computed in DECO.
                    if ((is_beq && zero) || (is_bne && !zero)) begin
                        sel_pc = 2'd1;
                        pc_ld  = 1'b1;
                    end
                    retire = 1'b1;
                end else if (is_mem) begin
                    state_d = MEM;
                end else if (is_r || is_addi) begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (is_mem) begin
                    sel_operB = 1'b1;
                    sel_operA = exe_a;
                    alu_fun   = exe_f;
                    sel_dir   = 1'b1;
                    if (is_lw) begin
                        mem_rd  = 1'b1;
                        state_d = WB;
                    end else begin
                        mem_wd = 1'b1;
                        retire = 1'b1;
                    end
                end
            end
            WB: begin
                if (is_r || is_addi || is_lw) begin
                    sel_operB = 1'b1;
                    sel_operA = exe_a;
                    alu_fun   = exe_f;
                    reg_wr    = 1'b1;
                    sel_dest  = is_r;
                    sel_dat   = is_lw;
                    retire    = 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase

        if (reset) begin
            pc_ld     = 1'b0;
            ir_w      = 1'b0;
            reg_rd    = 1'b0;
            reg_wr    = 1'b0;
            mem_rd    = 1'b0;
            mem_wd    = 1'b0;
            sel_dir   = 1'b0;
            sel_dest  = 1'b0;
            sel_dat   = 1'b0;
            sel_operB = 1'b0;
            sel_pc    = 2'd0;
            sel_operA = 3'd0;
            alu_fun   = ALU_ADD;
            illegal   = 1'b0;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            retired <= 32'd0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired <= retired + 32'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_control.sv
module tb_mips_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
    logic        pc_ld, ir_w, reg_rd, reg_wr, mem_rd, mem_wd;
    logic        sel_dir, sel_dest, sel_dat, sel_operB;
    logic [1:0]  sel_pc;
    logic [2:0]  sel_operA, alu_fun, state;
    logic        illegal;
    logic [31:0] retired;

    mips_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_ld(pc_ld), .ir_w(ir_w), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .mem_rd(mem_rd), .mem_wd(mem_wd), .sel_dir(sel_dir),
        .sel_dest(sel_dest), .sel_dat(sel_dat), .sel_operB(sel_operB),
        .sel_pc(sel_pc), .sel_operA(sel_operA), .alu_fun(alu_fun),
        .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_ld, ir_w, reg_rd, reg_wr, mem_rd, mem_wd;
        logic       sel_dir, sel_dest, sel_dat, sel_operB;
        logic [1:0] sel_pc;
        logic [2:0] sel_operA, alu_fun, state;
        logic       illegal;
    } outs_t;

    typedef struct {
        outs_t o;
        logic  z;
    } cyc_t;

    outs_t       dut_o;
    cyc_t        q[$];
    int          passed = 0;
    int          total = 0;
    logic [31:0] ret_model = 32'd0;

    assign dut_o = {pc_ld, ir_w, reg_rd, reg_wr, mem_rd, mem_wd, sel_dir,
                    sel_dest, sel_dat, sel_operB, sel_pc, sel_operA, alu_fun,
                    state, illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [2:0] r_op(input logic [5:0] f);
        case (f)
            6'h20:   return 3'd0;
            6'h22:   return 3'd1;
            6'h24:   return 3'd2;
            6'h25:   return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    function automatic bit r_ok(input logic [5:0] f);
        return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A;
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        return op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h05 ||
               op == 6'h08 || op == 6'h02;
    endfunction

    // Expected per-cycle outputs of one instruction, straight from the
    // instruction's cycle list: FETCH, DECO, then whatever phases it needs.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int zforce,
                         output bit legal);
        outs_t c;
        cyc_t  e;
        outs_t alu;
        bit    r, lw, sw, br, ex;
        q.delete();
        r     = (op == 6'h00) && r_ok(fn);
        lw    = op == 6'h23;
        sw    = op == 6'h2B;
        br    = op == 6'h04 || op == 6'h05;
        legal = r || op_ok(op);

        c = '0; c.state = 3'd0; c.mem_rd = 1; c.ir_w = 1; c.sel_operA = 3'd3; c.pc_ld = 1;
        e.o = c; e.z = 1'($urandom_range(0, 1)); q.push_back(e);

        c = '0; c.state = 3'd1; c.reg_rd = 1; c.sel_operA = 3'd2;
        if (!legal) c.illegal = 1;
        else if (op == 6'h02) begin c.sel_pc = 2'd2; c.pc_ld = 1; end
        e.o = c; e.z = 1'($urandom_range(0, 1)); q.push_back(e);
        if (!legal || op == 6'h02) return;

        alu = '0; alu.sel_operB = 1;
        if (r)       begin alu.sel_operA = 3'd0; alu.alu_fun = r_op(fn); end
        else if (br) begin alu.sel_operA = 3'd0; alu.alu_fun = 3'd1; end
        else         begin alu.sel_operA = 3'd1; alu.alu_fun = 3'd0; end

        c = alu; c.state = 3'd2;
        e.z = (zforce < 0) ? 1'($urandom_range(0, 1)) : zforce[0];
        if (br) begin
            ex = (op == 6'h04) ? e.z : !e.z;
            if (ex) begin c.pc_ld = 1; c.sel_pc = 2'd1; end
        end
        e.o = c; q.push_back(e);
        if (br) return;

        if (lw || sw) begin
            c = alu; c.state = 3'd3; c.sel_dir = 1; c.mem_rd = lw; c.mem_wd = sw;
            e.o = c; e.z = 1'($urandom_range(0, 1)); q.push_back(e);
            if (sw) return;
        end

        c = alu; c.state = 3'd4; c.reg_wr = 1; c.sel_dest = r; c.sel_dat = lw;
        e.o = c; e.z = 1'($urandom_range(0, 1)); q.push_back(e);
    endtask

    // Starts and ends just after a falling edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zforce, input string tag);
        bit legal;
        build(op, fn, zforce, legal);
        for (int i = 0; i < q.size(); i++) begin
            opcode = op; funct = fn; zero = q[i].z;
            #1;
            chk($sformatf("%s c%0d outs", tag, i), 32'(dut_o), 32'(q[i].o));
            chk($sformatf("%s c%0d retired", tag, i), retired, ret_model);
            @(negedge clk);
        end
        if (legal) ret_model = ret_model + 1;
    endtask

    task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn);
        int k;
        k  = $urandom_range(0, 11);
        fn = 6'($urandom);
        case (k)
            0: begin op = 6'h00; fn = 6'h20; end
            1: begin op = 6'h00; fn = 6'h22; end
            2: begin op = 6'h00; fn = 6'h24; end
            3: begin op = 6'h00; fn = 6'h25; end
            4: begin op = 6'h00; fn = 6'h2A; end
            5: op = 6'h23;
            6: op = 6'h2B;
            7: op = 6'h04;
            8: op = 6'h05;
            9: op = 6'h08;
            10: op = 6'h02;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    do op = 6'($urandom); while (op == 6'h00 || op_ok(op));
                end else begin
                    op = 6'h00;
                    do fn = 6'($urandom); while (r_ok(fn));
                end
            end
        endcase
    endtask

    initial begin
        logic [5:0] op, fn;
        bit legal;

        // Reset held: ungated FETCH would assert strobes.
        @(negedge clk); #1;
        chk("reset outs", 32'(dut_o), 32'd0);
        chk("reset retired", retired, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_instr(6'h00, 6'h22, -1, "sub");
        run_instr(6'h23, 6'h00, -1, "lw");
        run_instr(6'h2B, 6'h00, -1, "sw");
        run_instr(6'h04, 6'h11, 1, "beq_z1");
        run_instr(6'h04, 6'h11, 0, "beq_z0");
        run_instr(6'h05, 6'h11, 1, "bne_z1");
        run_instr(6'h05, 6'h11, 0, "bne_z0");
        run_instr(6'h02, 6'h3F, -1, "j");
        run_instr(6'h3F, 6'h20, -1, "ill_op");
        run_instr(6'h00, 6'h03, -1, "ill_fn");
        run_instr(6'h08, 6'h00, -1, "addi");
        run_instr(6'h00, 6'h2A, -1, "slt");

        for (int n = 0; n < 400; n++) begin
            rand_instr(op, fn);
            run_instr(op, fn, -1, "rnd");
        end

        // Reset in the WB cycle of add: outputs and retired clear at once.
        build(6'h00, 6'h20, -1, legal);
        for (int i = 0; i < 4; i++) begin
            opcode = 6'h00; funct = 6'h20; zero = q[i].z;
            #1;
            chk($sformatf("rstadd c%0d outs", i), 32'(dut_o), 32'(q[i].o));
            if (i < 3) @(negedge clk);
        end
        #1 reset = 1'b1;
        #1;
        chk("midwb outs", 32'(dut_o), 32'd0);
        chk("midwb retired", retired, 32'd0);
        ret_model = 32'd0;
        @(negedge clk); #1;
        chk("rst hold outs", 32'(dut_o), 32'd0);
        chk("rst hold reg_wr", 32'(reg_wr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_instr(6'h00, 6'h25, -1, "post_rst_or");
        for (int n = 0; n < 30; n++) begin
            rand_instr(op, fn);
            run_instr(op, fn, -1, "rnd2");
        end
        #1 chk("final retired", retired, ret_model);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
